sync_fifo_ctrl: RTL and testbench



---
 rtl/sync_fifo_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// sync_fifo_ctrl
// Single-clock FIFO with occupancy count, programmable almost-full /
// almost-empty thresholds, sticky overflow/underflow flags and a synchronous
// flush. FWFT selects registered-read (0) or first-word-fall-through (1).
//
// Ports:
//   clk           single clock, all state on rising edge
//   rst           asynchronous active-high reset
//   clear         synchronous flush, wins over same-cycle reads/writes
//   write_data    word to push
//   signal_write  push request
//   signal_read   pop request
//   read_data     output word (registered for FWFT=0, head word for FWFT=1)
//   full, empty, almost_full, almost_empty   decoded from registered level
//   level         current occupancy 0..DEPTH
//   overflow      sticky: a write was rejected
//   underflow     sticky: a read was rejected
// ---------------------------------------------------------------------------
module sync_fifo_ctrl #(
    parameter int WORDSIZE = 8,
    parameter int ADDRSIZE = 3,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = 2**ADDRSIZE - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic [WORDSIZE-1:0] write_data,
    input  logic                signal_write,
    input  logic                signal_read,
    output logic [WORDSIZE-1:0] read_data,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [ADDRSIZE:0]   level,
    output logic                overflow,
    output logic                underflow
);

    localparam int DEPTH = 2**ADDRSIZE;
    localparam logic [ADDRSIZE:0] DEPTH_L = (ADDRSIZE+1)'(DEPTH);
    localparam logic [ADDRSIZE:0] AF_L    = (ADDRSIZE+1)'(AF_LEVEL);
    localparam logic [ADDRSIZE:0] AE_L    = (ADDRSIZE+1)'(AE_LEVEL);
    localparam logic [ADDRSIZE:0] ONE_L   = (ADDRSIZE+1)'(1);
    localparam logic [ADDRSIZE:0] ZERO_L  = (ADDRSIZE+1)'(0);

    logic [WORDSIZE-1:0] mem_q [DEPTH];

    logic [ADDRSIZE:0] wptr_q, wptr_d;
    logic [ADDRSIZE:0] rptr_q, rptr_d;
    logic [ADDRSIZE:0] level_q, level_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              afull_q, afull_d;
    logic              aempty_q, aempty_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic rd_ok_s;
    logic wr_ok_s;
    logic mem_wr_s;

    // Accept decisions; a pop frees a slot, so a full FIFO still takes a write
    // on the same edge as an accepted read.
    always_comb begin
        rd_ok_s  = signal_read & ~empty_q;
        wr_ok_s  = signal_write & (~full_q | rd_ok_s);
        mem_wr_s = wr_ok_s & ~clear;
    end

    // Next-state for pointers, level, sticky errors and decoded flags.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (clear) begin
            wptr_d  = ZERO_L;
            rptr_d  = ZERO_L;
            level_d = ZERO_L;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (wr_ok_s) begin
                wptr_d = wptr_q + ONE_L;
            end else begin
                wptr_d = wptr_q;
            end
            if (rd_ok_s) begin
                rptr_d = rptr_q + ONE_L;
            end else begin
                rptr_d = rptr_q;
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   level_d = level_q + ONE_L;
                2'b01:   level_d = level_q - ONE_L;
                default: level_d = level_q;
            endcase
            ovf_d = ovf_q | (signal_write & ~wr_ok_s);
            udf_d = udf_q | (signal_read & ~rd_ok_s);
        end
        // Flags are registered from the next level so they track level_q
        // exactly, with no path from the request inputs to the outputs.
        full_d   = (level_d == DEPTH_L);
        empty_d  = (level_d == ZERO_L);
        afull_d  = (level_d >= AF_L);
        aempty_d = (level_d <= AE_L);
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q   <= ZERO_L;
            rptr_q   <= ZERO_L;
            level_q  <= ZERO_L;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage array; contents deliberately survive reset and flush.
    always_ff @(posedge clk) begin
        if (mem_wr_s) begin
            mem_q[wptr_q[ADDRSIZE-1:0]] <= write_data;
        end
    end

    generate
        if (FWFT == 0) begin : g_registered_read
            logic [WORDSIZE-1:0] read_data_q;

            // Output word loads only on an accepted pop, otherwise holds.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    read_data_q <= {WORDSIZE{1'b0}};
                end else if (clear) begin
                    read_data_q <= {WORDSIZE{1'b0}};
                end else if (rd_ok_s) begin
                    read_data_q <= mem_q[rptr_q[ADDRSIZE-1:0]];
                end else begin
                    read_data_q <= read_data_q;
                end
            end

            assign read_data = read_data_q;
        end else begin : g_fwft_read
            // Head word presented directly; meaningless while empty.
            assign read_data = mem_q[rptr_q[ADDRSIZE-1:0]];
        end
    endgenerate

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign level        = level_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    sync_fifo_ctrl_chk #(
        .ADDRSIZE (ADDRSIZE),
        .AF_LEVEL (AF_LEVEL),
        .AE_LEVEL (AE_LEVEL)
    ) u_chk (
        .clk     (clk),
        .rst     (rst),
        .wptr_i  (wptr_q),
        .rptr_i  (rptr_q),
        .level_i (level_q)
    );

endmodule

// ---------------------------------------------------------------------------
// sync_fifo_ctrl_chk
// Simulation checker: threshold parameter legality and agreement between the
// pointer distance and the level register.
//
// Ports:
//   clk, rst  clock and reset of the checked FIFO
//   wptr_i    write pointer
//   rptr_i    read pointer
//   level_i   level register
// ---------------------------------------------------------------------------
module sync_fifo_ctrl_chk #(
    parameter int ADDRSIZE = 3,
    parameter int AF_LEVEL = 7,
    parameter int AE_LEVEL = 1
) (
    input logic              clk,
    input logic              rst,
    input logic [ADDRSIZE:0] wptr_i,
    input logic [ADDRSIZE:0] rptr_i,
    input logic [ADDRSIZE:0] level_i
);

    localparam int DEPTH = 2**ADDRSIZE;

    logic [ADDRSIZE:0] dist_s;

    // Pointer distance, modulo the extended pointer width.
    always_comb begin
        dist_s = wptr_i - rptr_i;
    end

    // Check thresholds and pointer/level consistency every cycle out of reset.
    always @(posedge clk) begin
        if (!rst) begin
            assert ((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))
                else $error("sync_fifo_ctrl: illegal AE_LEVEL/AF_LEVEL");
            assert (dist_s == level_i)
                else $error("sync_fifo_ctrl: level disagrees with pointers");
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_ctrl
// Directed bench: one FWFT=0 and one FWFT=1 instance driven in lockstep.
// A table of vectors covers fill, overflow, full read+write, drain,
// underflow, empty read+write and flush; hand sequences cover wrap-around
// and an asynchronous reset in mid-cycle.
// ---------------------------------------------------------------------------
module tb_sync_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic [7:0] write_data;
    logic       signal_write;
    logic       signal_read;

    logic [7:0] rd0, rd1;
    logic       full0, empty0, af0, ae0, ovf0, udf0;
    logic       full1, empty1, af1, ae1, ovf1, udf1;
    logic [3:0] lvl0, lvl1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(.WORDSIZE(8), .ADDRSIZE(3), .FWFT(0), .AF_LEVEL(7), .AE_LEVEL(1)) u_dut0 (
        .clk(clk), .rst(rst), .clear(clear), .write_data(write_data),
        .signal_write(signal_write), .signal_read(signal_read),
        .read_data(rd0), .full(full0), .empty(empty0), .almost_full(af0),
        .almost_empty(ae0), .level(lvl0), .overflow(ovf0), .underflow(udf0)
    );

    sync_fifo_ctrl #(.WORDSIZE(8), .ADDRSIZE(3), .FWFT(1), .AF_LEVEL(7), .AE_LEVEL(1)) u_dut1 (
        .clk(clk), .rst(rst), .clear(clear), .write_data(write_data),
        .signal_write(signal_write), .signal_read(signal_read),
        .read_data(rd1), .full(full1), .empty(empty1), .almost_full(af1),
        .almost_empty(ae1), .level(lvl1), .overflow(ovf1), .underflow(udf1)
    );

    typedef struct {
        logic       clr;
        logic       wr;
        logic       rd;
        logic [7:0] wd;
        logic [3:0] lvl;
        logic       ovf;
        logic       udf;
        logic [7:0] rd0;
        logic       chk1;
        logic [7:0] rd1;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic clr, input logic wr, input logic rd, input logic [7:0] wd,
                       input logic [3:0] lvl, input logic ovf, input logic udf,
                       input logic [7:0] e_rd0, input logic chk1, input logic [7:0] e_rd1);
        vec_t v;
        v.clr = clr; v.wr = wr; v.rd = rd; v.wd = wd; v.lvl = lvl;
        v.ovf = ovf; v.udf = udf; v.rd0 = e_rd0; v.chk1 = chk1; v.rd1 = e_rd1;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Flags follow from level with DEPTH=8, AF_LEVEL=7, AE_LEVEL=1.
    task automatic check_all(input string tag, input logic [3:0] lvl, input logic ovf,
                             input logic udf, input logic [7:0] e_rd0,
                             input logic chk1, input logic [7:0] e_rd1);
        chk({tag, "_level0"}, 32'(lvl0), 32'(lvl));
        chk({tag, "_level1"}, 32'(lvl1), 32'(lvl));
        chk({tag, "_full"},   32'(full0),  32'(lvl == 4'd8));
        chk({tag, "_empty"},  32'(empty0), 32'(lvl == 4'd0));
        chk({tag, "_empty1"}, 32'(empty1), 32'(lvl == 4'd0));
        chk({tag, "_afull"},  32'(af0),    32'(lvl >= 4'd7));
        chk({tag, "_aempty"}, 32'(ae0),    32'(lvl <= 4'd1));
        chk({tag, "_ovf"},    32'(ovf0),   32'(ovf));
        chk({tag, "_udf"},    32'(udf0),   32'(udf));
        chk({tag, "_ovf1"},   32'(ovf1),   32'(ovf));
        chk({tag, "_rd0"},    32'(rd0),    32'(e_rd0));
        if (chk1) begin
            chk({tag, "_rd1"}, 32'(rd1), 32'(e_rd1));
        end
    endtask

    task automatic step(input logic clr, input logic wr, input logic rd, input logic [7:0] wd);
        clear        = clr;
        signal_write = wr;
        signal_read  = rd;
        write_data   = wd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] last0;

        rst = 1'b1; clear = 1'b0; signal_write = 1'b0; signal_read = 1'b0; write_data = 8'h00;

        // Fill with 0x01..0x08: FWFT head stays 0x01, registered output idle.
        for (int k = 1; k <= 8; k++) begin
            add(1'b0, 1'b1, 1'b0, 8'(k), 4'(k), 1'b0, 1'b0, 8'h00, 1'b1, 8'h01);
        end
        add(1'b0, 1'b1, 1'b0, 8'hAA, 4'd8, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01); // rejected write
        add(1'b0, 1'b0, 1'b1, 8'h00, 4'd7, 1'b1, 1'b0, 8'h01, 1'b1, 8'h02); // pop 0x01
        add(1'b0, 1'b1, 1'b0, 8'h09, 4'd8, 1'b1, 1'b0, 8'h01, 1'b1, 8'h02); // refill
        add(1'b0, 1'b1, 1'b1, 8'h55, 4'd8, 1'b1, 1'b0, 8'h02, 1'b1, 8'h03); // full rd+wr
        // Drain: 03..08, 09, 55.
        add(1'b0, 1'b0, 1'b1, 8'h00, 4'd7, 1'b1, 1'b0, 8'h03, 1'b1, 8'h04);
        add(1'b0, 1'b0, 1'b1, 8'h00, 4'd6, 1'b1, 1'b0, 8'h04, 1'b1, 8'h05);
        add(1'b0, 1'b0, 1'b1, 8'h00, 4'd5, 1'b1, 1'b0, 8'h05, 1'b1, 8'h06);
        add(1'b0, 1'b0, 1'b1, 8'h00, 4'd4, 1'b1, 1'b0, 8'h06, 1'b1, 8'h07);
        add(1'b0, 1'b0, 1'b1, 8'h00, 4'd3, 1'b1, 1'b0, 8'h07, 1'b1, 8'h08);
        add(1'b0, 1'b0, 1'b1, 8'h00, 4'd2, 1'b1, 1'b0, 8'h08, 1'b1, 8'h09);
        add(1'b0, 1'b0, 1'b1, 8'h00, 4'd1, 1'b1, 1'b0, 8'h09, 1'b1, 8'h55);
        add(1'b0, 1'b0, 1'b1, 8'h00, 4'd0, 1'b1, 1'b0, 8'h55, 1'b0, 8'h00);
        add(1'b0, 1'b0, 1'b1, 8'h00, 4'd0, 1'b1, 1'b1, 8'h55, 1'b0, 8'h00); // underflow
        add(1'b0, 1'b1, 1'b1, 8'h33, 4'd1, 1'b1, 1'b1, 8'h55, 1'b1, 8'h33); // empty rd+wr
        add(1'b0, 1'b0, 1'b1, 8'h00, 4'd0, 1'b1, 1'b1, 8'h33, 1'b0, 8'h00); // pop 0x33
        for (int k = 1; k <= 5; k++) begin
            add(1'b0, 1'b1, 1'b0, 8'(8'h60 + k), 4'(k), 1'b1, 1'b1, 8'h33, 1'b1, 8'h61);
        end
        add(1'b1, 1'b1, 1'b0, 8'h77, 4'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00); // flush beats write
        add(1'b0, 1'b1, 1'b0, 8'h88, 4'd1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h88);
        add(1'b0, 1'b0, 1'b1, 8'h00, 4'd0, 1'b0, 1'b0, 8'h88, 1'b0, 8'h00);

        // Reset state.
        @(posedge clk); #1;
        check_all("reset", 4'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].clr, vecs[i].wr, vecs[i].rd, vecs[i].wd);
            check_all($sformatf("v%0d", i), vecs[i].lvl, vecs[i].ovf, vecs[i].udf,
                      vecs[i].rd0, vecs[i].chk1, vecs[i].rd1);
        end

        // Wrap-around: level alternates 1/2 across 20 values, pointers wrap.
        last0 = 8'h88;
        step(1'b0, 1'b1, 1'b0, 8'd0);
        check_all("wrap_w0", 4'd1, 1'b0, 1'b0, last0, 1'b1, 8'd0);
        for (int i = 1; i < 20; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'(i));
            check_all($sformatf("wrap_w%0d", i), 4'd2, 1'b0, 1'b0, last0, 1'b1, 8'(i - 1));
            step(1'b0, 1'b0, 1'b1, 8'd0);
            last0 = 8'(i - 1);
            check_all($sformatf("wrap_r%0d", i - 1), 4'd1, 1'b0, 1'b0, last0, 1'b1, 8'(i));
        end
        step(1'b0, 1'b0, 1'b1, 8'd0);
        check_all("wrap_r19", 4'd0, 1'b0, 1'b0, 8'd19, 1'b0, 8'd0);

        // Build some state, then reset asynchronously between edges.
        step(1'b0, 1'b0, 1'b1, 8'd0);
        check_all("pre_udf", 4'd0, 1'b0, 1'b1, 8'd19, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b0, 8'hA1);
        step(1'b0, 1'b1, 1'b1, 8'hA2);
        check_all("pre_rst", 4'd1, 1'b0, 1'b1, 8'hA1, 1'b1, 8'hA2);
        signal_write = 1'b0; signal_read = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_all("async_rst", 4'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        #1 rst = 1'b0;
        step(1'b0, 1'b1, 1'b0, 8'h5A);
        check_all("post_rst", 4'd1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h5A);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check_all("post_rst_rd", 4'd0, 1'b0, 1'b0, 8'h5A, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
